syn_pcm_pingpong_buf: RTL

Parametrised double-buffered PCM capture store between the codec ADC deserialiser and the FFT engine (fgyrus). It generalises the fixed two-channel, 128-sample capture RAM to N channels, any sample width and any power-of-two depth. The writer fills one bank while the consumer reads the other. Bank swaps, the buffer-ready pulse, consumer release and overrun counting are added behaviour.

---
 rtl/syn_pcm_buf_pkg.sv | 28 ++
 rtl/syn_pcm_pingpong_buf_if.sv | 33 +++
 rtl/syn_pcm_buf_ram.sv | 30 +++
 rtl/syn_pcm_pingpong_buf.sv | 128 ++++++++++++
 4 files changed

// File: rtl/syn_pcm_buf_pkg.sv
// Shared types, defaults and width helpers for the ping-pong PCM capture buffer.
package syn_pcm_buf_pkg;

  localparam int unsigned DefPcmW      = 32;
  localparam int unsigned DefNumChnls  = 2;
  localparam int unsigned DefNumSamples = 128;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StWaitRel
  } pcm_buf_state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // A single-channel build still needs a one-bit channel field in rd_addr.
  function automatic int unsigned chnl_w(input int unsigned n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/syn_pcm_pingpong_buf_if.sv
// Capture/read bus of the ping-pong PCM buffer; master is the writer/reader side.
interface syn_pcm_pingpong_buf_if
  import syn_pcm_buf_pkg::*;
#(
  parameter int unsigned PCM_W       = DefPcmW,
  parameter int unsigned NUM_CHNLS   = DefNumChnls,
  parameter int unsigned NUM_SAMPLES = DefNumSamples,
  parameter int unsigned OVR_CNT_W   = 16
);
  localparam int unsigned SmplW = clog2(NUM_SAMPLES);
  localparam int unsigned ChnlW = chnl_w(NUM_CHNLS);

  logic                       cfg_en;
  logic                       pcm_in_valid;
  logic [NUM_CHNLS*PCM_W-1:0] pcm_in_data;
  logic                       pcm_rdy;
  logic [SmplW+ChnlW-1:0]     rd_addr;
  logic [PCM_W-1:0]           rd_data;
  logic                       rd_release;
  logic                       rd_busy;
  logic [OVR_CNT_W-1:0]       ovr_cnt;

  modport master (
    output cfg_en, pcm_in_valid, pcm_in_data, rd_addr, rd_release,
    input  pcm_rdy, rd_data, rd_busy, ovr_cnt
  );

  modport slave (
    input  cfg_en, pcm_in_valid, pcm_in_data, rd_addr, rd_release,
    output pcm_rdy, rd_data, rd_busy, ovr_cnt
  );

endinterface

// File: rtl/syn_pcm_buf_ram.sv
// Simple dual-port frame RAM: synchronous write, registered read with reset.
module syn_pcm_buf_ram #(
  parameter int unsigned DataW = 64,
  parameter int unsigned AddrW = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [DataW-1:0] wr_data_i,
  input  logic [AddrW-1:0] rd_addr_i,
  output logic [DataW-1:0] rd_data_o
);
  localparam int unsigned Depth = 1 << AddrW;

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rd_data_q <= '0;
    else         rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/syn_pcm_pingpong_buf.sv
// Double-buffered N-channel PCM capture store: writer fills one bank while the
// reader owns the other; banks swap on fill/release, drops are counted.
module syn_pcm_pingpong_buf
  import syn_pcm_buf_pkg::*;
#(
  parameter int unsigned PCM_W       = DefPcmW,
  parameter int unsigned NUM_CHNLS   = DefNumChnls,
  parameter int unsigned NUM_SAMPLES = DefNumSamples,
  parameter int unsigned OVR_CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  syn_pcm_pingpong_buf_if.slave  pcm_io
);
  localparam int unsigned SmplW  = clog2(NUM_SAMPLES);
  localparam int unsigned ChnlW  = chnl_w(NUM_CHNLS);
  localparam int unsigned FrameW = NUM_CHNLS * PCM_W;
  localparam logic [SmplW-1:0] LastPtr = SmplW'(NUM_SAMPLES - 1);

  pcm_buf_state_t       state_q, state_d;
  logic                 wr_bank_q, wr_bank_d;
  logic [SmplW-1:0]     wr_ptr_q, wr_ptr_d;
  logic                 rd_busy_q, rd_busy_d;
  logic                 pcm_rdy_q, pcm_rdy_d;
  logic [OVR_CNT_W-1:0] ovr_cnt_q, ovr_cnt_d;
  logic [ChnlW-1:0]     chnl_q;
  logic                 wr_en;
  logic                 swap;
  logic [FrameW-1:0]    frame_rd;
  logic [PCM_W-1:0]     rd_data;

  always_comb begin
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    wr_ptr_d  = wr_ptr_q;
    rd_busy_d = rd_busy_q;
    pcm_rdy_d = 1'b0;
    ovr_cnt_d = ovr_cnt_q;
    wr_en     = 1'b0;
    swap      = 1'b0;
    if (!pcm_io.cfg_en) begin
      state_d   = StIdle;
      wr_ptr_d  = '0;
      rd_busy_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d  = StFill;
          wr_ptr_d = '0;
        end
        StFill: begin
          // An early release frees the reader; a swap below re-claims it.
          if (pcm_io.rd_release) rd_busy_d = 1'b0;
          if (pcm_io.pcm_in_valid) begin
            wr_en = 1'b1;
            if (wr_ptr_q == LastPtr) begin
              wr_ptr_d = '0;
              if (!rd_busy_q || pcm_io.rd_release) swap = 1'b1;
              else                                 state_d = StWaitRel;
            end else begin
              wr_ptr_d = wr_ptr_q + SmplW'(1);
            end
          end
        end
        StWaitRel: begin
          if (pcm_io.pcm_in_valid && (ovr_cnt_q != '1)) ovr_cnt_d = ovr_cnt_q + OVR_CNT_W'(1);
          if (pcm_io.rd_release) begin
            swap    = 1'b1;
            state_d = StFill;
          end
        end
        default: state_d = StIdle;
      endcase
      if (swap) begin
        wr_bank_d = ~wr_bank_q;
        rd_busy_d = 1'b1;
        pcm_rdy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wr_bank_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_busy_q <= 1'b0;
      pcm_rdy_q <= 1'b0;
      ovr_cnt_q <= '0;
      chnl_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_bank_q <= wr_bank_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_busy_q <= rd_busy_d;
      pcm_rdy_q <= pcm_rdy_d;
      ovr_cnt_q <= ovr_cnt_d;
      chnl_q    <= pcm_io.rd_addr[ChnlW-1:0];
    end
  end

  syn_pcm_buf_ram #(
    .DataW (FrameW),
    .AddrW (SmplW + 1)
  ) u_ram (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wr_en_i   (wr_en),
    .wr_addr_i ({wr_bank_q, wr_ptr_q}),
    .wr_data_i (pcm_io.pcm_in_data),
    .rd_addr_i ({~wr_bank_q, pcm_io.rd_addr[SmplW+ChnlW-1:ChnlW]}),
    .rd_data_o (frame_rd)
  );

  // Channel select follows the RAM register so both share the same read cycle.
  always_comb begin
    rd_data = '0;
    for (int unsigned c = 0; c < NUM_CHNLS; c++) begin
      if (chnl_q == ChnlW'(c)) rd_data = frame_rd[c*PCM_W +: PCM_W];
    end
  end

  assign pcm_io.rd_data = rd_data;
  assign pcm_io.pcm_rdy = pcm_rdy_q;
  assign pcm_io.rd_busy = rd_busy_q;
  assign pcm_io.ovr_cnt = ovr_cnt_q;

endmodule
